// File: rtl/updi_pkg.sv
// rtl/updi_pkg.sv - shared types for the UPDI frame-buffer arbiter
package updi_pkg;

    localparam int UPDI_ADDR_W = 7;
    localparam int UPDI_DATA_W = 12;

    typedef logic [UPDI_ADDR_W-1:0] updi_addr_t;
    typedef logic [UPDI_DATA_W-1:0] updi_word_t;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED0,
        LOCKED1
    } arb_lock_t;

    typedef logic req_id_t;

endpackage

// File: rtl/updi_rd_tag_pipe.sv
// rtl/updi_rd_tag_pipe.sv - read tag shift register routing returned words to their issuer
module updi_rd_tag_pipe
    import updi_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  req_id_t push_id,
    output logic    rvalid0,
    output logic    rvalid1
);

    localparam int DEPTH = 1 + RD_LAT;

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] id_q;
    logic [DEPTH-1:0] id_d;

    // Stage 0 covers the strobe cycle; the last stage lines up with dout0.
    always_comb begin
        vld_d = {vld_q[DEPTH-2:0], push};
        id_d  = {id_q[DEPTH-2:0], push_id};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign rvalid0 = vld_q[DEPTH-1] & ~id_q[DEPTH-1];
    assign rvalid1 = vld_q[DEPTH-1] &  id_q[DEPTH-1];

endmodule

// File: rtl/updi_mem_arbiter.sv
// rtl/updi_mem_arbiter.sv - round-robin, lockable arbiter sharing the UPDI frame buffer
module updi_mem_arbiter
    import updi_pkg::*;
#(
    parameter int ADDR_W = UPDI_ADDR_W,
    parameter int DATA_W = UPDI_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0
);

    arb_lock_t         lock_q, lock_d;
    req_id_t           rr_ptr_q, rr_ptr_d;
    logic              csb0_q, csb0_d;
    logic              web0_q, web0_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [DATA_W-1:0] din0_q, din0_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

    logic              gnt0, gnt1, acc;
    req_id_t           acc_id;
    logic              acc_we, acc_lock;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              tag_rv0, tag_rv1;

    // A held lock excludes the other requester even while the owner is idle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (lock_q)
                LOCKED0: gnt0 = r0_valid;
                LOCKED1: gnt1 = r1_valid;
                default: begin
                    if (r0_valid && r1_valid) begin
                        gnt0 = (rr_ptr_q == 1'b0);
                        gnt1 = (rr_ptr_q == 1'b1);
                    end else begin
                        gnt0 = r0_valid;
                        gnt1 = r1_valid;
                    end
                end
            endcase
        end
    end

    assign r0_ready  = gnt0;
    assign r1_ready  = gnt1;
    assign acc       = gnt0 | gnt1;
    assign acc_id    = gnt1;
    assign acc_we    = acc_id ? r1_we    : r0_we;
    assign acc_lock  = acc_id ? r1_lock  : r0_lock;
    assign acc_addr  = acc_id ? r1_addr  : r0_addr;
    assign acc_wdata = acc_id ? r1_wdata : r0_wdata;

    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            UNLOCKED: if (acc && acc_lock) lock_d = acc_id ? LOCKED1 : LOCKED0;
            LOCKED0:  if (gnt0 && !r0_lock) lock_d = UNLOCKED;
            LOCKED1:  if (gnt1 && !r1_lock) lock_d = UNLOCKED;
            default:  lock_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= UNLOCKED;
        end else begin
            lock_q <= lock_d;
        end
    end

    always_comb begin
        rr_ptr_d = acc ? ~acc_id : rr_ptr_q;
        csb0_d   = ~acc;
        web0_d   = ~(acc & acc_we);
        addr0_d  = acc ? acc_addr : addr0_q;
        din0_d   = (acc && acc_we) ? acc_wdata : din0_q;
    end

    updi_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .push    (acc & ~acc_we),
        .push_id (acc_id),
        .rvalid0 (tag_rv0),
        .rvalid1 (tag_rv1)
    );

    assign r0_rvalid = tag_rv0 & ~rst;
    assign r1_rvalid = tag_rv1 & ~rst;

    // Returned word is passed straight through on its rvalid cycle, then held.
    always_comb begin
        r0_rdata_d = r0_rvalid ? dout0 : r0_rdata_q;
        r1_rdata_d = r1_rvalid ? dout0 : r1_rdata_q;
    end

    assign r0_rdata = r0_rdata_d;
    assign r1_rdata = r1_rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= 1'b0;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            addr0_q    <= '0;
            din0_q     <= '0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            csb0_q     <= csb0_d;
            web0_q     <= web0_d;
            addr0_q    <= addr0_d;
            din0_q     <= din0_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
        end
    end

    assign csb0  = csb0_q;
    assign web0  = web0_q;
    assign addr0 = addr0_q;
    assign din0  = din0_q;

endmodule

// File: tb/tb_updi_mem_arbiter.sv
// tb/tb_updi_mem_arbiter.sv - self-checking bench for updi_mem_arbiter at RD_LAT 1 and 3
module tb_updi_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r0_valid, r0_we, r0_lock;
    logic [6:0]  r0_addr;
    logic [11:0] r0_wdata;
    logic        r1_valid, r1_we, r1_lock;
    logic [6:0]  r1_addr;
    logic [11:0] r1_wdata;

    logic        r0_ready_a, r1_ready_a, r0_rvalid_a, r1_rvalid_a;
    logic [11:0] r0_rdata_a, r1_rdata_a;
    logic        csb0_a, web0_a;
    logic [6:0]  addr0_a;
    logic [11:0] din0_a, dout0_a;

    logic        r0_ready_b, r1_ready_b, r0_rvalid_b, r1_rvalid_b;
    logic [11:0] r0_rdata_b, r1_rdata_b;
    logic        csb0_b, web0_b;
    logic [6:0]  addr0_b;
    logic [11:0] din0_b, dout0_b;

    updi_mem_arbiter #(.ADDR_W(7), .DATA_W(12), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready_a), .r0_we(r0_we), .r0_lock(r0_lock),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid_a), .r0_rdata(r0_rdata_a),
        .r1_valid(r1_valid), .r1_ready(r1_ready_a), .r1_we(r1_we), .r1_lock(r1_lock),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid_a), .r1_rdata(r1_rdata_a),
        .csb0(csb0_a), .web0(web0_a), .addr0(addr0_a), .din0(din0_a), .dout0(dout0_a)
    );

    updi_mem_arbiter #(.ADDR_W(7), .DATA_W(12), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready_b), .r0_we(r0_we), .r0_lock(r0_lock),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid_b), .r0_rdata(r0_rdata_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready_b), .r1_we(r1_we), .r1_lock(r1_lock),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid_b), .r1_rdata(r1_rdata_b),
        .csb0(csb0_b), .web0(web0_b), .addr0(addr0_b), .din0(din0_b), .dout0(dout0_b)
    );

    // SRAM stand-ins: read data emerges RD_LAT cycles after the strobe cycle
    bit [11:0] sram_a [128];
    bit [11:0] sram_b [128];
    bit [11:0] pipe_a;
    bit [11:0] pipe_b [3];

    always @(posedge clk) begin
        if (csb0_a === 1'b0) begin
            if (web0_a === 1'b0) sram_a[addr0_a] <= din0_a;
            else                 pipe_a <= sram_a[addr0_a];
        end
    end
    assign dout0_a = pipe_a;

    always @(posedge clk) begin
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (csb0_b === 1'b0) begin
            if (web0_b === 1'b0) sram_b[addr0_b] <= din0_b;
            else                 pipe_b[0] <= sram_b[addr0_b];
        end
    end
    assign dout0_b = pipe_b[2];

    // Reference model: words in a flat array, pending returns in queues with due cycles
    typedef struct packed {
        int          due;
        logic        id;
        logic [11:0] data;
    } ret_t;

    int          total, bad, cyc, last_gnt;
    int          m_ptr, m_owner;
    bit   [11:0] shadow [128];
    ret_t        q_a[$];
    ret_t        q_b[$];
    logic        e_csb, e_web;
    logic [6:0]  e_addr;
    logic [11:0] e_din;
    logic [1:0]  e_rv_a, e_rv_b;
    logic [11:0] e_rd_a [2];
    logic [11:0] e_rd_b [2];

    function automatic int model_grant();
        if (rst) return -1;
        if (m_owner == 0) return r0_valid ? 0 : -1;
        if (m_owner == 1) return r1_valid ? 1 : -1;
        if (r0_valid && r1_valid) return m_ptr;
        if (r0_valid) return 0;
        if (r1_valid) return 1;
        return -1;
    endfunction

    task automatic tick();
        int          g;
        logic        was_rst, we, lk;
        logic [6:0]  a;
        logic [11:0] wd;
        ret_t        r;
        g        = model_grant();
        last_gnt = g;
        was_rst  = rst;
        we = (g == 1) ? r1_we    : r0_we;
        lk = (g == 1) ? r1_lock  : r0_lock;
        a  = (g == 1) ? r1_addr  : r0_addr;
        wd = (g == 1) ? r1_wdata : r0_wdata;
        @(posedge clk);
        cyc++;
        if (was_rst) begin
            m_ptr = 0; m_owner = -1;
            q_a.delete(); q_b.delete();
            e_csb = 1'b1; e_web = 1'b1; e_addr = '0; e_din = '0;
            e_rd_a[0] = '0; e_rd_a[1] = '0; e_rd_b[0] = '0; e_rd_b[1] = '0;
        end else begin
            e_csb = 1'b1; e_web = 1'b1;
            if (g >= 0) begin
                e_csb  = 1'b0;
                e_web  = ~we;
                e_addr = a;
                if (we) begin
                    e_din     = wd;
                    shadow[a] = wd;
                end else begin
                    q_a.push_back('{cyc + 1, g[0], shadow[a]});
                    q_b.push_back('{cyc + 3, g[0], shadow[a]});
                end
                m_ptr   = 1 - g;
                m_owner = lk ? g : -1;
            end
        end
        @(negedge clk);
        e_rv_a = '0;
        e_rv_b = '0;
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
            r = q_a.pop_front(); e_rv_a[r.id] = 1'b1; e_rd_a[r.id] = r.data;
        end
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
            r = q_b.pop_front(); e_rv_b[r.id] = 1'b1; e_rd_b[r.id] = r.data;
        end
    endtask

    task automatic idle(int n);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 7'd3; r0_wdata = 12'h111;
        tick();
        #1;
        total++;
        if ({r0_ready_a, r0_ready_b} !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b want 00", {r0_ready_a, r0_ready_b});
        end
        tick();
        rst = 1'b0; r0_valid = 1'b0;
        #1;
        total++;
        if ({csb0_a, web0_a, addr0_a, din0_a} !== {1'b1, 1'b1, 7'd0, 12'd0}) begin
            bad++; $display("FAIL reset_drive_a: got %h want %h", {csb0_a, web0_a, addr0_a, din0_a}, {1'b1, 1'b1, 7'd0, 12'd0});
        end
        total++;
        if ({csb0_b, web0_b, addr0_b, din0_b} !== {1'b1, 1'b1, 7'd0, 12'd0}) begin
            bad++; $display("FAIL reset_drive_b: got %h want %h", {csb0_b, web0_b, addr0_b, din0_b}, {1'b1, 1'b1, 7'd0, 12'd0});
        end
        total++;
        if ({r0_ready_a, r1_ready_a, r0_rvalid_a, r1_rvalid_a, r0_rdata_a, r1_rdata_a, r0_rvalid_b, r1_rvalid_b, r0_rdata_b, r1_rdata_b} !== '0) begin
            bad++; $display("FAIL reset_outputs: got nonzero ready/rvalid/rdata, want all zero");
        end
    endtask

    task automatic test_single_write();
        logic seen;
        r0_valid = 1'b1; r0_we = 1'b1; r0_lock = 1'b0; r0_addr = 7'd5; r0_wdata = 12'h6A3;
        #1;
        total++;
        if ({r0_ready_a, r1_ready_a} !== 2'b10) begin
            bad++; $display("FAIL write_ready: got %b want 10", {r0_ready_a, r1_ready_a});
        end
        tick();
        r0_valid = 1'b0;
        #1;
        total++;
        if ({csb0_a, web0_a, addr0_a, din0_a, csb0_b, web0_b, addr0_b, din0_b} !== {2'b00, 7'd5, 12'h6A3, 2'b00, 7'd5, 12'h6A3}) begin
            bad++; $display("FAIL write_drive: got %h/%h/%h/%h want 0/0/5/6a3", csb0_a, web0_a, addr0_a, din0_a);
        end
        seen = 1'b0;
        tick();
        #1;
        total++;
        if ({csb0_a, csb0_b} !== 2'b11) begin
            bad++; $display("FAIL write_csb_release: got %b want 11", {csb0_a, csb0_b});
        end
        repeat (4) begin
            seen |= r0_rvalid_a | r1_rvalid_a | r0_rvalid_b | r1_rvalid_b;
            tick();
            #1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL write_no_rvalid: got %b want 0", seen);
        end
    endtask

    task automatic test_alternate();
        logic [11:0] d1, d2;
        d1 = 12'($urandom); d2 = 12'($urandom);
        r0_valid = 1'b1; r0_we = 1'b1; r0_lock = 1'b0; r0_addr = 7'd1; r0_wdata = d1;
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_we = 1'b1; r1_lock = 1'b0; r1_addr = 7'd2; r1_wdata = d2;
        tick();
        r1_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 7'd1;
        r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 7'd2;
        for (int k = 0; k < 8; k++) begin
            #1;
            total++;
            if ({r0_ready_a, r1_ready_a, r0_ready_b, r1_ready_b} !== {k % 2 == 0, k % 2 == 1, k % 2 == 0, k % 2 == 1}) begin
                bad++; $display("FAIL alt_grant k=%0d: got %b", k, {r0_ready_a, r1_ready_a, r0_ready_b, r1_ready_b});
            end
            if (k >= 2) begin
                total++;
                if ({r0_rvalid_a, r1_rvalid_a, ((k % 2 == 1) ? r1_rdata_a : r0_rdata_a)} !== {k % 2 == 0, k % 2 == 1, ((k % 2 == 1) ? d2 : d1)}) begin
                    bad++; $display("FAIL alt_return_a k=%0d: got %b %b %h", k, r0_rvalid_a, r1_rvalid_a, (k % 2 == 1) ? r1_rdata_a : r0_rdata_a);
                end
            end
            if (k >= 4) begin
                total++;
                if ({r0_rvalid_b, r1_rvalid_b, ((k % 2 == 1) ? r1_rdata_b : r0_rdata_b)} !== {k % 2 == 0, k % 2 == 1, ((k % 2 == 1) ? d2 : d1)}) begin
                    bad++; $display("FAIL alt_return_b k=%0d: got %b %b %h", k, r0_rvalid_b, r1_rvalid_b, (k % 2 == 1) ? r1_rdata_b : r0_rdata_b);
                end
            end
            tick();
        end
        idle(6);
    endtask

    task automatic test_lock_burst();
        logic [1:0] exp_rdy [5] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b10};
        logic       r1v     [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       r1lk    [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 5; c++) begin
            r0_valid = (c >= 1); r0_we = 1'b0; r0_lock = 1'b0; r0_addr = 7'd5;
            r1_valid = r1v[c]; r1_we = 1'b1; r1_lock = r1lk[c];
            r1_addr = 7'(40 + c); r1_wdata = 12'($urandom);
            #1;
            total++;
            if ({r0_ready_a, r1_ready_a} !== exp_rdy[c] || {r0_ready_b, r1_ready_b} !== exp_rdy[c]) begin
                bad++; $display("FAIL lock_burst c=%0d: got %b/%b want %b", c, {r0_ready_a, r1_ready_a}, {r0_ready_b, r1_ready_b}, exp_rdy[c]);
            end
            tick();
        end
        idle(6);
    endtask

    task automatic test_reset_midflight();
        logic seen;
        r0_valid = 1'b1; r0_we = 1'b0; r0_lock = 1'b1; r0_addr = 7'd5;
        tick();
        r0_valid = 1'b0; r0_lock = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if ({csb0_a, csb0_b} !== 2'b11) begin
            bad++; $display("FAIL midrst_csb: got %b want 11", {csb0_a, csb0_b});
        end
        seen = r0_rvalid_a | r0_rvalid_b;
        r1_valid = 1'b1; r1_we = 1'b1; r1_lock = 1'b0; r1_addr = 7'd11; r1_wdata = 12'h0C3;
        #1;
        total++;
        if ({r1_ready_a, r1_ready_b} !== 2'b11) begin
            bad++; $display("FAIL midrst_lock_cleared: got %b want 11", {r1_ready_a, r1_ready_b});
        end
        tick();
        r1_valid = 1'b0;
        repeat (5) begin
            #1;
            seen |= r0_rvalid_a | r0_rvalid_b;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL midrst_dropped_read: got rvalid %b want 0", seen);
        end
        r0_valid = 1'b1; r0_we = 1'b1; r0_lock = 1'b0; r0_addr = 7'd10; r0_wdata = 12'h5A5;
        tick();
        r0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 7'd11;
        #1;
        total++;
        if ({r0_ready_a, r1_ready_a, r0_ready_b, r1_ready_b} !== 4'b1010) begin
            bad++; $display("FAIL midrst_ptr: got %b want 1010", {r0_ready_a, r1_ready_a, r0_ready_b, r1_ready_b});
        end
        tick();
        idle(4);
    endtask

    task automatic test_lat3_sweep();
        logic [11:0] d;
        d = 12'($urandom);
        r0_valid = 1'b1; r0_we = 1'b0; r0_lock = 1'b0; r0_addr = 7'd5;
        #1;
        total++;
        if ({r0_ready_a, r0_ready_b} !== 2'b11) begin
            bad++; $display("FAIL lat3_issue: got %b want 11", {r0_ready_a, r0_ready_b});
        end
        tick();
        for (int c = 1; c <= 8; c++) begin
            r0_valid = 1'b0;
            r1_valid = (c <= 2); r1_we = (c == 1); r1_lock = 1'b0; r1_addr = 7'd60; r1_wdata = d;
            #1;
            total++;
            if ({r0_rvalid_b, r1_rvalid_b} !== {c == 4, c == 6}) begin
                bad++; $display("FAIL lat3_rvalid_b c=%0d: got %b", c, {r0_rvalid_b, r1_rvalid_b});
            end
            total++;
            if ({r0_rvalid_a, r1_rvalid_a} !== {c == 2, c == 4}) begin
                bad++; $display("FAIL lat3_rvalid_a c=%0d: got %b", c, {r0_rvalid_a, r1_rvalid_a});
            end
            if (c == 4) begin
                total++;
                if (r0_rdata_b !== 12'h6A3) begin
                    bad++; $display("FAIL lat3_r0_data: got %h want 6a3", r0_rdata_b);
                end
            end
            if (c >= 6) begin
                total++;
                if (r1_rdata_b !== d) begin
                    bad++; $display("FAIL lat3_r1_data c=%0d: got %h want %h", c, r1_rdata_b, d);
                end
            end
            tick();
        end
    endtask

    task automatic test_addr_wrap();
        r0_valid = 1'b1; r0_we = 1'b0; r0_lock = 1'b0; r0_addr = 7'd127;
        tick();
        r0_addr = 7'd0;
        #1;
        total++;
        if ({csb0_a, web0_a, addr0_a, csb0_b, web0_b, addr0_b} !== {2'b01, 7'd127, 2'b01, 7'd127}) begin
            bad++; $display("FAIL wrap_127: got %b %b %0d want 0 1 127", csb0_a, web0_a, addr0_a);
        end
        tick();
        r0_valid = 1'b0;
        #1;
        total++;
        if ({csb0_a, web0_a, addr0_a, csb0_b, web0_b, addr0_b} !== {2'b01, 7'd0, 2'b01, 7'd0}) begin
            bad++; $display("FAIL wrap_0: got %b %b %0d want 0 1 0", csb0_a, web0_a, addr0_a);
        end
        total++;
        if ({r0_rvalid_a, r0_rdata_a} !== {e_rv_a[0], e_rd_a[0]} || r0_rvalid_a !== 1'b1) begin
            bad++; $display("FAIL wrap_ret127: got %b %h want 1 %h", r0_rvalid_a, r0_rdata_a, e_rd_a[0]);
        end
        tick();
        #1;
        total++;
        if ({csb0_a, r0_rvalid_a, r0_rdata_a} !== {1'b1, e_rv_a[0], e_rd_a[0]} || r0_rvalid_a !== 1'b1) begin
            bad++; $display("FAIL wrap_ret0: got %b %b %h want 1 1 %h", csb0_a, r0_rvalid_a, r0_rdata_a, e_rd_a[0]);
        end
        idle(6);
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 400; i++) begin
            if (!(r0_valid && last_gnt != 0)) begin
                r0_valid = ($urandom_range(0, 3) != 0);
                r0_we    = 1'($urandom_range(0, 1));
                r0_lock  = ($urandom_range(0, 3) == 0);
                r0_addr  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
                r0_wdata = 12'($urandom);
            end
            if (!(r1_valid && last_gnt != 1)) begin
                r1_valid = ($urandom_range(0, 3) != 0);
                r1_we    = 1'($urandom_range(0, 1));
                r1_lock  = ($urandom_range(0, 3) == 0);
                r1_addr  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
                r1_wdata = 12'($urandom);
            end
            #1;
            g = model_grant();
            total++;
            if ({r0_ready_a, r1_ready_a, r0_ready_b, r1_ready_b} !== {g == 0, g == 1, g == 0, g == 1}) begin
                bad++; $display("FAIL rnd_grant i=%0d: got %b want grant %0d", i, {r0_ready_a, r1_ready_a, r0_ready_b, r1_ready_b}, g);
            end
            total++;
            if ({csb0_a, web0_a, addr0_a, din0_a} !== {e_csb, e_web, e_addr, e_din}) begin
                bad++; $display("FAIL rnd_drive_a i=%0d: got %h want %h", i, {csb0_a, web0_a, addr0_a, din0_a}, {e_csb, e_web, e_addr, e_din});
            end
            total++;
            if ({csb0_b, web0_b, addr0_b, din0_b} !== {e_csb, e_web, e_addr, e_din}) begin
                bad++; $display("FAIL rnd_drive_b i=%0d: got %h want %h", i, {csb0_b, web0_b, addr0_b, din0_b}, {e_csb, e_web, e_addr, e_din});
            end
            total++;
            if ({r0_rvalid_a, r1_rvalid_a, r0_rdata_a, r1_rdata_a} !== {e_rv_a[0], e_rv_a[1], e_rd_a[0], e_rd_a[1]}) begin
                bad++; $display("FAIL rnd_return_a i=%0d: got %b%b %h %h want %b %h %h", i, r0_rvalid_a, r1_rvalid_a, r0_rdata_a, r1_rdata_a, e_rv_a, e_rd_a[0], e_rd_a[1]);
            end
            total++;
            if ({r0_rvalid_b, r1_rvalid_b, r0_rdata_b, r1_rdata_b} !== {e_rv_b[0], e_rv_b[1], e_rd_b[0], e_rd_b[1]}) begin
                bad++; $display("FAIL rnd_return_b i=%0d: got %b%b %h %h want %b %h %h", i, r0_rvalid_b, r1_rvalid_b, r0_rdata_b, r1_rdata_b, e_rv_b, e_rd_b[0], e_rd_b[1]);
            end
            tick();
        end
        idle(6);
    endtask

    initial begin
        rst = 1'b1;
        r0_valid = 1'b0; r0_we = 1'b0; r0_lock = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1'b0; r1_we = 1'b0; r1_lock = 1'b0; r1_addr = '0; r1_wdata = '0;
        total = 0; bad = 0; cyc = 0; last_gnt = -1;
        m_ptr = 0; m_owner = -1;
        e_csb = 1'b1; e_web = 1'b1; e_addr = '0; e_din = '0;
        e_rv_a = '0; e_rv_b = '0;
        e_rd_a[0] = '0; e_rd_a[1] = '0; e_rd_b[0] = '0; e_rd_b[1] = '0;
        test_reset();
        test_single_write();
        test_alternate();
        test_lock_burst();
        test_reset_midflight();
        test_lat3_sweep();
        test_addr_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
